// File: rtl/t06_sound_pkg.sv
// Shared types and jingle constants for the team-06 sound sequencer.
// Jingles are short fixed note lists played one note per step with a silent gap after each.
package t06_sound_pkg;

    localparam int NOTE_W   = 6;
    localparam int STEP_W   = 2;
    localparam int GOOD_LEN = 3;
    localparam int BAD_LEN  = 2;

    localparam logic [NOTE_W-1:0] GOOD_NOTE_0 = 6'd24;
    localparam logic [NOTE_W-1:0] GOOD_NOTE_1 = 6'd28;
    localparam logic [NOTE_W-1:0] GOOD_NOTE_2 = 6'd31;
    localparam logic [NOTE_W-1:0] BAD_NOTE_0  = 6'd12;
    localparam logic [NOTE_W-1:0] BAD_NOTE_1  = 6'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic {
        EV_GOOD = 1'b0,
        EV_BAD  = 1'b1
    } event_t;

    // Index of the final step of a jingle.
    function automatic logic [STEP_W-1:0] jingle_last(input event_t code);
        return (code == EV_BAD) ? STEP_W'(BAD_LEN - 1) : STEP_W'(GOOD_LEN - 1);
    endfunction

endpackage

// File: rtl/t06_event_fifo.sv
// Small FIFO of 1-bit collision event codes; a push when full is ignored.
// Push and pop in the same cycle are both honoured.
module t06_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/t06_sound_sequencer.sv
// Queues good/bad collision events and plays each as a fixed jingle of timed notes and gaps.
// Outputs feed the note lookup / PWM tone generator; all are registered.
module t06_sound_sequencer
    import t06_sound_pkg::*;
#(
    parameter int TICKS_PER_STEP = 1_200_000,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              good_collision,
    input  logic              bad_collision,
    output logic [NOTE_W-1:0] note,
    output logic              tone_en,
    output logic              busy,
    output logic              dropped
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP);
    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((TICKS_PER_STEP >> 3) - 1);

    logic              good_p0;
    logic              bad_p0;
    logic              good_evt;
    logic              bad_evt;
    logic              evt_push;
    logic              drop_evt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_data;
    logic              start_jingle;
    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic [STEP_W-1:0] step;
    event_t            jingle_code;
    logic              tick_done;
    logic              step_last;
    logic [NOTE_W-1:0] note_nxt;
    logic              tone_nxt;

    function automatic logic [NOTE_W-1:0] jingle_note(input event_t code,
                                                      input logic [STEP_W-1:0] idx);
        logic [NOTE_W-1:0] n;
        n = '0;
        if (code == EV_BAD) begin
            case (idx)
                2'd0:    n = BAD_NOTE_0;
                2'd1:    n = BAD_NOTE_1;
                default: n = '0;
            endcase
        end else begin
            case (idx)
                2'd0:    n = GOOD_NOTE_0;
                2'd1:    n = GOOD_NOTE_1;
                2'd2:    n = GOOD_NOTE_2;
                default: n = '0;
            endcase
        end
        return n;
    endfunction

    // Stage p0: previous input levels for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_p0 <= 1'b0;
            bad_p0  <= 1'b0;
        end else begin
            good_p0 <= good_collision;
            bad_p0  <= bad_collision;
        end
    end

    // A simultaneous GOOD+BAD keeps only BAD and counts as a drop.
    assign good_evt = enable & good_collision & ~good_p0;
    assign bad_evt  = enable & bad_collision & ~bad_p0;
    assign evt_push = good_evt | bad_evt;
    assign drop_evt = (good_evt & bad_evt) | (evt_push & fifo_full);

    assign start_jingle = (state == ST_IDLE) & ~fifo_empty & enable;
    assign tick_done    = (tick_cnt == '0);
    assign step_last    = (step == jingle_last(jingle_code));

    t06_event_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (evt_push),
        .push_data(bad_evt),
        .pop      (start_jingle),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_jingle) state_nxt = ST_PLAY;
            ST_PLAY: if (enable && tick_done) state_nxt = ST_GAP;
            ST_GAP:  if (enable && tick_done) state_nxt = step_last ? ST_IDLE : ST_PLAY;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tick counter and step pointer freeze whenever enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt    <= '0;
            step        <= '0;
            jingle_code <= EV_GOOD;
        end else if (start_jingle) begin
            tick_cnt    <= PLAY_LOAD;
            step        <= '0;
            jingle_code <= event_t'(fifo_data);
        end else if (enable && state != ST_IDLE) begin
            if (!tick_done) begin
                tick_cnt <= tick_cnt - 1'b1;
            end else if (state == ST_PLAY) begin
                tick_cnt <= GAP_LOAD;
            end else if (!step_last) begin
                tick_cnt <= PLAY_LOAD;
                step     <= step + 1'b1;
            end
        end
    end

    always_comb begin
        note_nxt = note;
        tone_nxt = 1'b0;
        case (state)
            ST_IDLE: note_nxt = '0;
            ST_PLAY: begin
                note_nxt = jingle_note(jingle_code, step);
                tone_nxt = enable;
            end
            default: note_nxt = note;
        endcase
    end

    // Stage p1: registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            note    <= '0;
            tone_en <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            note    <= note_nxt;
            tone_en <= tone_nxt;
            busy    <= (state != ST_IDLE) | ~fifo_empty;
            dropped <= drop_evt;
        end
    end

endmodule

// File: tb/tb_t06_sound_sequencer.sv
// Randomised and directed bench for t06_sound_sequencer against a segment-schedule model.
// The model expands each queued event into a list of (note, sounding, length) segments.
module tb_t06_sound_sequencer;

    localparam int TPS   = 16;
    localparam int GAPL  = TPS >> 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       good_collision;
    logic       bad_collision;
    logic [5:0] note;
    logic       tone_en;
    logic       busy;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t06_sound_sequencer #(
        .TICKS_PER_STEP(TPS),
        .QUEUE_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .good_collision(good_collision),
        .bad_collision (bad_collision),
        .note          (note),
        .tone_en       (tone_en),
        .busy          (busy),
        .dropped       (dropped)
    );

    typedef struct {
        int nt;
        bit snd;
        int len;
    } seg_t;

    seg_t segs[$];
    bit   evq[$];
    bit   pg;
    bit   pb;
    int   m_note;
    bit   m_tone;
    bit   m_busy;
    bit   m_drop;

    int edge_idx;
    int first_tone;
    int tone_cnt;
    int drop_cnt;
    int busy_cnt;
    int busy_fall;
    int cnt24;
    int win_tone;
    bit prev_busy;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic start_jingle(input bit code);
        int   notes[$];
        seg_t s;
        if (code) notes = '{12, 11};
        else      notes = '{24, 28, 31};
        foreach (notes[i]) begin
            s.nt = notes[i]; s.snd = 1'b1; s.len = TPS;
            segs.push_back(s);
            s.snd = 1'b0; s.len = GAPL;
            segs.push_back(s);
        end
    endtask

    // Predicts outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit   ge;
        bit   be;
        bit   full_pre;
        seg_t s;
        if (rst) begin
            segs.delete();
            evq.delete();
            pg = 1'b0; pb = 1'b0;
            m_note = 0; m_tone = 1'b0; m_busy = 1'b0; m_drop = 1'b0;
            return;
        end
        if (segs.size() == 0) begin
            m_note = 0;
            m_tone = 1'b0;
        end else begin
            m_note = segs[0].nt;
            m_tone = segs[0].snd && enable;
        end
        m_busy = (segs.size() != 0) || (evq.size() != 0);
        ge = enable && good_collision && !pg;
        be = enable && bad_collision && !pb;
        pg = good_collision;
        pb = bad_collision;
        full_pre = (evq.size() == DEPTH);
        m_drop = (ge && be) || ((ge || be) && full_pre);
        if (segs.size() != 0) begin
            if (enable) begin
                s = segs[0];
                s.len--;
                if (s.len == 0) void'(segs.pop_front());
                else            segs[0] = s;
            end
        end else if (evq.size() != 0 && enable) begin
            start_jingle(evq.pop_front());
        end
        if ((ge || be) && !full_pre) evq.push_back(be);
    endtask

    task automatic clear_stats();
        edge_idx   = 0;
        first_tone = -1;
        tone_cnt   = 0;
        drop_cnt   = 0;
        busy_cnt   = 0;
        busy_fall  = -1;
        cnt24      = 0;
        win_tone   = 0;
        prev_busy  = busy;
    endtask

    task automatic tick();
        int e;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = edge_idx;
        edge_idx++;
        chk("note", note, m_note);
        chk("tone_en", tone_en, m_tone);
        chk("busy", busy, m_busy);
        chk("dropped", dropped, m_drop);
        if (tone_en === 1'b1) begin
            tone_cnt++;
            if (first_tone < 0) first_tone = e;
            if (note == 6'd24) cnt24++;
            if (e >= 10 && e <= 19) win_tone++;
        end
        if (dropped === 1'b1) drop_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (prev_busy && busy === 1'b0 && busy_fall < 0) busy_fall = e;
        prev_busy = (busy === 1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; good_collision = 1'b0; bad_collision = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; good_collision = 1'b0; bad_collision = 1'b0;
        @(negedge clk);

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            enable         = 1'($urandom);
            good_collision = 1'($urandom);
            bad_collision  = 1'($urandom);
            tick();
        end
        chk("reset_note", note, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0; enable = 1'b1; good_collision = 1'b0; bad_collision = 1'b0;
        run(2);

        // Single GOOD jingle.
        clear_stats();
        good_collision = 1'b1; tick();
        good_collision = 1'b0; run(60);
        chk("good_first_tone", first_tone, 2);
        chk("good_tone_cycles", tone_cnt, 3 * TPS);
        chk("good_busy_fall", busy_fall, 2 + 3 * (TPS + GAPL));

        // Simultaneous GOOD and BAD.
        do_reset();
        clear_stats();
        good_collision = 1'b1; bad_collision = 1'b1; tick();
        good_collision = 1'b0; bad_collision = 1'b0; run(45);
        chk("both_drop_pulses", drop_cnt, 1);
        chk("both_tone_cycles", tone_cnt, 2 * TPS);
        chk("both_no_good_note", cnt24, 0);

        // Six GOOD pulses two cycles apart.
        do_reset();
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            good_collision = (i % 2 == 0);
            tick();
        end
        good_collision = 1'b0;
        run(5 * (3 * (TPS + GAPL) + 1) + 10);
        chk("six_drop_pulses", drop_cnt, 1);
        chk("six_tone_cycles", tone_cnt, 5 * 3 * TPS);

        // Enable low for 10 cycles during note 24, with an ignored edge inside.
        do_reset();
        clear_stats();
        good_collision = 1'b1; tick();
        good_collision = 1'b0;
        for (int i = 1; i < 30; i++) begin
            enable = !(i >= 10 && i <= 19);
            good_collision = (i == 12 || i == 13);
            tick();
        end
        enable = 1'b1; good_collision = 1'b0;
        run(60);
        chk("en_low_window_tone", win_tone, 0);
        chk("en_note24_cycles", cnt24, TPS);
        chk("en_total_tone", tone_cnt, 3 * TPS);

        // Reset during note 28 with two events queued.
        do_reset();
        clear_stats();
        for (int i = 0; i < 25; i++) begin
            good_collision = (i == 0 || i == 2 || i == 4);
            tick();
        end
        good_collision = 1'b0;
        chk("pre_rst_note", note, 28);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_idle_note", note, 0);
        chk("rst_idle_tone", tone_en, 0);
        clear_stats();
        run(80);
        chk("post_rst_tone", tone_cnt, 0);
        chk("post_rst_busy", busy_cnt, 0);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 24) == 0) good_collision = ~good_collision;
            if ($urandom_range(0, 30) == 0) bad_collision = ~bad_collision;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
